// File: rtl/note_sequencer.sv
// note_sequencer: plays a fixed 32-entry song ROM or passes manual keys through
// to a tone generator.
//
// Ports:
//   clk_in    - system clock (1 MHz nominal)
//   rst       - synchronous active-high reset
//   auto      - level, 1 = auto-play requested; 0 forces IDLE
//   Key       - manual keys, [6:0] low 1..7, [13:7] middle 1..7, 1 = pressed
//   note_code - 0 = rest, 1..7 = low 1..7, 8..14 = middle 1..7
//   src_auto  - 1 when note_code comes from the song ROM
//   song_addr - ROM entry index being played
//   beat_tick - one-cycle pulse per completed beat
//   song_done - one-cycle pulse when the song end is reached
//
// All outputs are registered and describe the action taken in the previous
// cycle. A beat's tick therefore appears together with that beat's last
// (gap) output cycle.
module note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 250000,
  parameter int unsigned GAP_CYCLES  = 20000,
  parameter int unsigned LOOP        = 0
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        auto,
  input  logic [13:0] Key,
  output logic [3:0]  note_code,
  output logic        src_auto,
  output logic [4:0]  song_addr,
  output logic        beat_tick,
  output logic        song_done
);

  localparam int unsigned CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [4:0]    addr_q;
  logic [3:0]    rem_q;
  logic [CW-1:0] cnt_q;

  logic [7:0] rom_entry;
  logic [3:0] rom_note;
  logic [3:0] rom_beats;
  logic [3:0] man_note;
  logic       in_gap;

  // Song ROM: {note[7:4], beats[3:0]}; beats = 0 marks the end of the song.
  always_comb begin
    rom_entry = 8'h00;
    case (addr_q)
      5'd0:    rom_entry = 8'h11;
      5'd1:    rom_entry = 8'h11;
      5'd2:    rom_entry = 8'h51;
      5'd3:    rom_entry = 8'h51;
      5'd4:    rom_entry = 8'h61;
      5'd5:    rom_entry = 8'h61;
      5'd6:    rom_entry = 8'h52;
      default: rom_entry = 8'h00;
    endcase
  end

  assign rom_note  = rom_entry[7:4];
  assign rom_beats = rom_entry[3:0];

  // Scan from the highest key down so the lowest pressed key wins.
  always_comb begin
    man_note = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (Key[13 - i]) man_note = 4'(14 - i);
    end
  end

  // Rest window at the tail of the final beat of the current entry.
  assign in_gap = (rem_q == 4'd1) && ((32'(cnt_q) + GAP_CYCLES) >= BEAT_CYCLES);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      note_code <= '0;
      src_auto  <= 1'b0;
      song_addr <= '0;
      beat_tick <= 1'b0;
      song_done <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      song_done <= 1'b0;
      if (!auto) begin
        state_q   <= S_IDLE;
        addr_q    <= '0;
        rem_q     <= '0;
        cnt_q     <= '0;
        note_code <= man_note;
        src_auto  <= 1'b0;
        song_addr <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            note_code <= man_note;
            src_auto  <= 1'b0;
            song_addr <= '0;
            state_q   <= S_LOAD;
          end
          S_LOAD: begin
            note_code <= '0;
            src_auto  <= 1'b0;
            song_addr <= addr_q;
            if (rom_beats == '0) begin
              state_q   <= S_DONE;
              song_done <= 1'b1;
            end else begin
              rem_q   <= rom_beats;
              cnt_q   <= '0;
              state_q <= S_PLAY;
            end
          end
          // A released PAUSE behaves exactly like a PLAY cycle at the held
          // count, so resume needs no extra cycle; a pressed key in PLAY
          // pauses before the terminal count is consumed.
          S_PLAY, S_PAUSE: begin
            song_addr <= addr_q;
            if (|Key) begin
              state_q   <= S_PAUSE;
              note_code <= man_note;
              src_auto  <= 1'b0;
            end else begin
              state_q   <= S_PLAY;
              src_auto  <= 1'b1;
              note_code <= in_gap ? 4'd0 : rom_note;
              if (cnt_q == BEAT_LAST) begin
                beat_tick <= 1'b1;
                cnt_q     <= '0;
                if (rem_q == 4'd1) begin
                  rem_q  <= '0;
                  addr_q <= addr_q + 5'd1;
                  if (addr_q == '1) begin
                    state_q   <= S_DONE;
                    song_done <= 1'b1;
                  end else begin
                    state_q <= S_LOAD;
                  end
                end else begin
                  rem_q <= rem_q - 4'd1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_DONE: begin
            note_code <= '0;
            src_auto  <= 1'b0;
            song_addr <= addr_q;
            if (LOOP != 0) begin
              addr_q  <= '0;
              state_q <= S_LOAD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
